// File: rtl/bsa_sequencer.sv
// bsa_sequencer -- control stage in front of the bit-serial adder.
//
// Takes operand pairs over a valid/ready handshake. For each pair it clears the
// adder, loads the operands, waits out the serial run, and then captures the
// parallel sum and final carry. The result goes downstream over a second
// valid/ready handshake. Only one add is in flight at a time.
//
// Build option:
//   BSA_SEQ_FIFO_EN  defined   -> FIFO_DEPTH-entry operand FIFO; in_ready = !full
//   BSA_SEQ_FIFO_EN  undefined -> single holding register; accepts only in IDLE
//
// Ports:
//   clk, clr               clock, synchronous active-high reset
//   in_valid/in_ready      operand handshake, carrying in_a and in_b
//   bsa_a, bsa_b           operands to the adder, held from one LOAD to the next
//   bsa_clr, bsa_load      adder clear and parallel-load strobes
//   bsa_sum, bsa_cout      adder parallel sum and combinational carry out
//   out_valid/out_ready    result handshake, carrying out_sum and out_cout
//   busy                   high whenever the FSM is not in IDLE
module bsa_sequencer #(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int RUN_CYCLES = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] bsa_a,
  output logic [WIDTH-1:0] bsa_b,
  output logic             bsa_clr,
  output logic             bsa_load,
  input  logic [WIDTH-1:0] bsa_sum,
  input  logic             bsa_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  localparam int CNT_W = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RUN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, RUN, CAPTURE} state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] count_reg;
  logic             carry_hold_reg;
  logic             bsa_load_reg;
  logic [WIDTH-1:0] bsa_a_reg;
  logic [WIDTH-1:0] bsa_b_reg;
  logic             out_valid_reg;
  logic [WIDTH-1:0] out_sum_reg;
  logic             out_cout_reg;

  logic             accept;
  logic             pair_avail;
  logic [WIDTH-1:0] pop_a;
  logic [WIDTH-1:0] pop_b;

  assign accept = in_valid & in_ready;

`ifdef BSA_SEQ_FIFO_EN
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

  // The pointers carry one extra wrap bit, so full and empty can be told apart.
  logic [2*WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]     wr_ptr_reg;
  logic [PTR_W:0]     rd_ptr_reg;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                      (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
  // A pop happens only in CLEAR. CLEAR is entered only with data queued,
  // or with a pair being written on that same edge.
  assign fifo_pop   = (state_reg == CLEAR);
  assign in_ready   = !fifo_full;
  assign pair_avail = !fifo_empty | accept;
  // The head entry is read here; bsa_a/bsa_b register it during CLEAR.
  assign {pop_a, pop_b} = fifo_mem[rd_ptr_reg[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (accept) begin
      fifo_mem[wr_ptr_reg[PTR_W-1:0]] <= {in_a, in_b};
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (accept) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (fifo_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
    end
  end
`else
  logic             hold_full_reg;
  logic [WIDTH-1:0] hold_a_reg;
  logic [WIDTH-1:0] hold_b_reg;

  assign in_ready   = (state_reg == IDLE) & !hold_full_reg;
  assign pair_avail = hold_full_reg | accept;
  assign pop_a      = hold_a_reg;
  assign pop_b      = hold_b_reg;

  // A pair is accepted only in IDLE, and the FSM moves to CLEAR on that same
  // edge. The register is therefore full for exactly the CLEAR cycle.
  always_ff @(posedge clk) begin
    if (clr) begin
      hold_full_reg <= 1'b0;
      hold_a_reg    <= '0;
      hold_b_reg    <= '0;
    end else if (accept) begin
      hold_full_reg <= 1'b1;
      hold_a_reg    <= in_a;
      hold_b_reg    <= in_b;
    end else if (state_reg == CLEAR) begin
      hold_full_reg <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg      <= IDLE;
      count_reg      <= '0;
      carry_hold_reg <= 1'b0;
      bsa_load_reg   <= 1'b0;
      bsa_a_reg      <= '0;
      bsa_b_reg      <= '0;
      out_valid_reg  <= 1'b0;
      out_sum_reg    <= '0;
      out_cout_reg   <= 1'b0;
    end else begin
      // Consumer takes the result. CAPTURE below may set valid again on the same edge.
      if (out_valid_reg && out_ready) begin
        out_valid_reg <= 1'b0;
      end
      case (state_reg)
        IDLE: begin
          if (pair_avail) begin
            state_reg <= CLEAR;
          end
        end
        CLEAR: begin
          bsa_a_reg    <= pop_a;
          bsa_b_reg    <= pop_b;
          bsa_load_reg <= 1'b1;
          state_reg    <= LOAD;
        end
        LOAD: begin
          bsa_load_reg <= 1'b0;
          count_reg    <= '0;
          state_reg    <= RUN;
        end
        RUN: begin
          count_reg <= count_reg + CNT_ONE;
          // The adder is working on its top bit, so its carry out is the final carry.
          if (count_reg == CNT_LAST) begin
            carry_hold_reg <= bsa_cout;
            state_reg      <= CAPTURE;
          end
        end
        CAPTURE: begin
          // Wait here while the previous result is still unclaimed; the adder keeps its sum.
          if (!out_valid_reg || out_ready) begin
            out_sum_reg   <= bsa_sum;
            out_cout_reg  <= carry_hold_reg;
            out_valid_reg <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Combinational, so a reset arriving mid-run clears the adder in that same cycle.
  assign bsa_clr   = clr | (state_reg == CLEAR);
  assign bsa_load  = bsa_load_reg;
  assign bsa_a     = bsa_a_reg;
  assign bsa_b     = bsa_b_reg;
  assign out_valid = out_valid_reg;
  assign out_sum   = out_sum_reg;
  assign out_cout  = out_cout_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_bsa_sequencer.sv
// Testbench for bsa_sequencer. Includes a behavioural bit-serial adder that adds one
// bit per clock after load. Uses table-driven vectors, a queue scoreboard, and
// hand-written sequences for latency, output stall, mid-run reset and FIFO back-pressure.
module tb_bsa_sequencer;

  localparam int W = 8;

  logic         clk;
  logic         clr;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [W-1:0] bsa_a;
  logic [W-1:0] bsa_b;
  logic         bsa_clr;
  logic         bsa_load;
  logic [W-1:0] bsa_sum;
  logic         bsa_cout;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         busy;

  bsa_sequencer #(.WIDTH(W), .FIFO_DEPTH(4), .RUN_CYCLES(8)) dut (
    .clk       (clk),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .bsa_a     (bsa_a),
    .bsa_b     (bsa_b),
    .bsa_clr   (bsa_clr),
    .bsa_load  (bsa_load),
    .bsa_sum   (bsa_sum),
    .bsa_cout  (bsa_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Behavioural serial adder: LSB first, one bit per clock after the load edge.
  logic [W-1:0] m_a;
  logic [W-1:0] m_b;
  logic [W-1:0] m_s;
  logic         m_c;
  int           m_n = W;
  logic         m_cout;
  assign m_cout   = (m_a[0] & m_b[0]) | (m_c & (m_a[0] ^ m_b[0]));
  assign bsa_sum  = m_s;
  assign bsa_cout = m_cout;

  always @(posedge clk) begin
    if (bsa_clr) begin
      m_a <= '0; m_b <= '0; m_s <= '0; m_c <= 1'b0; m_n <= W;
    end else if (bsa_load) begin
      m_a <= bsa_a; m_b <= bsa_b; m_s <= '0; m_c <= 1'b0; m_n <= 0;
    end else if (m_n < W) begin
      m_s <= {m_a[0] ^ m_b[0] ^ m_c, m_s[W-1:1]};
      m_c <= m_cout;
      m_a <= m_a >> 1;
      m_b <= m_b >> 1;
      m_n <= m_n + 1;
    end
  end

  int errors = 0;
  int checks = 0;
  int delivered = 0;
  logic [W:0] sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: one line per delivered result, compared against the scoreboard head.
  always @(negedge clk) begin
    logic [W:0] e;
    if (!clr && out_valid && out_ready) begin
      checks++;
      delivered++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got sum=%02h cout=%0b expected none", out_sum, out_cout);
      end else begin
        e = sb_q.pop_front();
        $display("result: sum=%02h cout=%0b expect sum=%02h cout=%0b", out_sum, out_cout, e[W-1:0], e[W]);
        if ({out_cout, out_sum} !== e) begin
          errors++;
          $display("FAIL result: got %03h expected %03h", {out_cout, out_sum}, e);
        end
      end
    end
  end

  // Offers one pair. On acceptance it pushes the expectation. Returns at posedge+1.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W:0] exp,
                      output int acc_edge, output int waits);
    in_a = a; in_b = b; in_valid = 1'b1; waits = 0; acc_edge = 0;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      waits++;
      if (waits > 300) begin
        chk("in_ready_timeout", 32'(in_ready), 32'h1);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    sb_q.push_back(exp);
    acc_edge = cyc + 1;
    $display("send: a=%02h b=%02h expect=%03h", a, b, exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !busy && !out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, 32'(ok), 32'h1);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  vec_t vecs[12];
  int   acc;
  int   wt;
  int   lat;
  int   d0;
  bit   seen;
  bit   stop_tog;

  initial begin
    vecs[0]  = '{8'h5A, 8'h33, 8'h8D, 1'b0};
    vecs[1]  = '{8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[2]  = '{8'h80, 8'h80, 8'h00, 1'b1};
    vecs[3]  = '{8'h01, 8'h02, 8'h03, 1'b0};
    vecs[4]  = '{8'h00, 8'h00, 8'h00, 1'b0};
    vecs[5]  = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
    vecs[6]  = '{8'h7F, 8'h01, 8'h80, 1'b0};
    vecs[7]  = '{8'hAA, 8'h55, 8'hFF, 1'b0};
    vecs[8]  = '{8'h12, 8'h34, 8'h46, 1'b0};
    vecs[9]  = '{8'hF0, 8'h20, 8'h10, 1'b1};
    vecs[10] = '{8'h64, 8'h9C, 8'h00, 1'b1};
    vecs[11] = '{8'h39, 8'h4E, 8'h87, 1'b0};

    clr = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1; stop_tog = 1'b0;

    // Reset values
    @(negedge clk);
    chk("bsa_clr_during_clr", 32'(bsa_clr), 32'h1);
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
    chk("reset out_valid", 32'(out_valid), 32'h0);
    chk("reset out_sum", 32'(out_sum), 32'h0);
    chk("reset out_cout", 32'(out_cout), 32'h0);
    chk("reset bsa_a", 32'(bsa_a), 32'h0);
    chk("reset bsa_b", 32'(bsa_b), 32'h0);
    chk("reset bsa_load", 32'(bsa_load), 32'h0);
    chk("reset bsa_clr", 32'(bsa_clr), 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset in_ready", 32'(in_ready), 32'h1);
    @(posedge clk); #1;

    // Latency of the first operation: out_valid rises 11 edges after the accept edge
    send(8'h5A, 8'h33, 9'h08D, acc, wt);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = cyc - acc;
        break;
      end
    end
    chk("latency", 32'(lat), 32'd11);
    @(posedge clk); #1;
    wait_drain("drain_latency");

    // Table vectors, sent back to back
    for (int i = 0; i < 12; i++) begin
      send(vecs[i].a, vecs[i].b, {vecs[i].cout, vecs[i].sum}, acc, wt);
    end
    wait_drain("drain_table");

    // Output stall: first result held for 20 cycles, second op stalls in CAPTURE
    out_ready = 1'b0;
    d0 = delivered;
    send(8'h21, 8'h43, 9'h064, acc, wt);
    send(8'h10, 8'h05, 9'h015, acc, wt);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("stall first valid", 32'(seen), 32'h1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("stall out_valid held", 32'(out_valid), 32'h1);
      chk("stall out_sum held", 32'({out_cout, out_sum}), 32'h064);
    end
    chk("stall busy in capture", 32'(busy), 32'h1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain("drain_stall");
    chk("stall delivered count", 32'(delivered - d0), 32'd2);

    // Random operands, with out_ready toggling at random
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          logic [W-1:0] ra;
          logic [W-1:0] rb;
          ra = W'($urandom_range(0, 255));
          rb = W'($urandom_range(0, 255));
          send(ra, rb, {1'b0, ra} + {1'b0, rb}, acc, wt);
        end
        stop_tog = 1'b1;
      end
      begin
        while (!stop_tog) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    wait_drain("drain_random");

`ifdef BSA_SEQ_FIFO_EN
    // FIFO back-pressure: with the output stalled, the sixth pair must wait
    out_ready = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send(8'(i + 1), 8'h10, 9'(i + 17), acc, wt);
      if (wt > 0) seen = 1'b1;
    end
    chk("fifo backpressure", 32'(seen), 32'h1);
    out_ready = 1'b1;
    wait_drain("drain_fifo");
`endif

    // Reset mid-RUN drops the in-flight operation
    send(8'hFF, 8'hFF, 9'h1FE, acc, wt);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bsa_load) begin
        seen = 1'b1;
        break;
      end
    end
    chk("midrun load seen", 32'(seen), 32'h1);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    clr = 1'b1;
    sb_q.delete();
    @(negedge clk);
    chk("midrun bsa_clr", 32'(bsa_clr), 32'h1);
    chk("midrun busy before", 32'(busy), 32'h1);
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
    chk("midrun busy after", 32'(busy), 32'h0);
    chk("midrun out_valid", 32'(out_valid), 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("midrun no result", 32'(seen), 32'h0);
    @(posedge clk); #1;
    send(8'h01, 8'h02, 9'h003, acc, wt);
    wait_drain("drain_after_clr");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
